fnd_scan_controller: RTL and testbench

Parametrised multi-digit 7-segment (FND) scan driver for common-anode displays. Holds an N-digit hex/BCD value plus per-digit decimal points and time-multiplexes one digit at a time. A prescaler sets the per-digit dwell time. Display updates are tear-free: a new value is taken only at frame boundaries. Sits between the counter/datapath logic and the board FND pins.

---
 rtl/fnd_scan_controller.sv | 159 +++++++++++++++
 tb/tb_fnd_scan_controller.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// One digit is lit at a time. A prescaler sets how long each digit stays lit.
// A newly loaded value is held in a pending register and moved into the
// displayed (shadow) copy only when the scan wraps to digit 0, so a frame
// never shows a mix of the old and new values.
// Optional build macro: FND_LZB_EN enables leading-zero blanking.
module fnd_scan_controller #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 100000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_en,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    output logic [NUM_DIGITS-1:0]   o_digit,
    output logic [7:0]              o_font,
    output logic                    o_frame
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] seg_font(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Scan state: prescaler and digit index.
    logic [CNT_W-1:0]        cnt_p0;
    logic [IDX_W-1:0]        idx_p0;
    // Load path: the pending copy and the copy currently on display.
    logic [4*NUM_DIGITS-1:0] pend_val;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pend_vld;
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    // Registered pin drivers.
    logic [NUM_DIGITS-1:0]   digit_p1;
    logic [7:0]              font_p1;
    logic                    frame_p1;

    logic                    tick;
    logic                    wrap;
    logic [3:0]              cur_nib;
    logic [6:0]              cur_seg;
    logic [NUM_DIGITS-1:0]   lz_blank;

    assign tick    = i_en && (cnt_p0 == CNT_LAST);
    assign wrap    = tick && (idx_p0 == IDX_LAST);
    assign cur_nib = shadow_val[{idx_p0, 2'b00} +: 4];

`ifdef FND_LZB_EN
    // Mark digits whose own nibble and every more significant nibble are zero.
    always_comb begin
        logic run;
        lz_blank = '0;
        run      = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            run         = run & (shadow_val[4*k +: 4] == 4'h0);
            lz_blank[k] = run;
        end
    end
`else
    assign lz_blank = '0;
`endif

    assign cur_seg = lz_blank[idx_p0] ? 7'h7F : seg_font(cur_nib);

    // Prescaler: count dwell cycles while enabled, hold while disabled.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_p0 <= '0;
        end else if (i_en) begin
            cnt_p0 <= (cnt_p0 == CNT_LAST) ? '0 : cnt_p0 + CNT_W'(1);
        end
    end

    // Digit index: advance on each dwell tick and wrap after the last digit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            idx_p0 <= '0;
        end else if (tick) begin
            idx_p0 <= wrap ? '0 : idx_p0 + IDX_W'(1);
        end
    end

    // Load path: a load on the wrap tick goes straight to display, otherwise it waits for the next wrap.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_vld   <= 1'b0;
            shadow_val <= '0;
            shadow_dp  <= '0;
        end else if (wrap && i_load) begin
            shadow_val <= i_value;
            shadow_dp  <= i_dp;
            pend_vld   <= 1'b0;
        end else if (wrap) begin
            if (pend_vld) begin
                shadow_val <= pend_val;
                shadow_dp  <= pend_dp;
            end
            pend_vld <= 1'b0;
        end else if (i_load) begin
            pend_val <= i_value;
            pend_dp  <= i_dp;
            pend_vld <= 1'b1;
        end
    end

    // ---- stage p0 -> p1: drive anode, segments and frame pulse from the scan state ----
    // Output registers: light the indexed digit, or blank everything while disabled.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            digit_p1 <= '1;
            font_p1  <= 8'hFF;
            frame_p1 <= 1'b0;
        end else begin
            frame_p1 <= wrap;
            if (i_en) begin
                digit_p1 <= ~(NUM_DIGITS'(1) << idx_p0);
                font_p1  <= {~shadow_dp[idx_p0], cur_seg};
            end else begin
                digit_p1 <= '1;
                font_p1  <= 8'hFF;
            end
        end
    end

    assign o_digit = digit_p1;
    assign o_font  = font_p1;
    assign o_frame = frame_p1;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller with NUM_DIGITS=4, SCAN_DIV=4.
// Cycle offsets j are counted from the cycle in which o_frame is high (j=0);
// digit k is on the pins during j = 4k+1 .. 4k+4 and the next pulse is at j=16.
module tb_fnd_scan_controller;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_en;
    logic        i_load;
    logic [15:0] i_value;
    logic [3:0]  i_dp;
    logic [3:0]  o_digit;
    logic [7:0]  o_font;
    logic        o_frame;

    int    n_vec = 0;
    int    n_err = 0;
    string phase = "init";

    fnd_scan_controller #(
        .NUM_DIGITS(4),
        .SCAN_DIV  (4)
    ) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_en   (i_en),
        .i_load (i_load),
        .i_value(i_value),
        .i_dp   (i_dp),
        .o_digit(o_digit),
        .o_font (o_font),
        .o_frame(o_frame)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %0h, expected %0h", phase, tag, got, exp);
        end
    endtask

    function automatic logic [6:0] font_tbl(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [7:0] exp_font(input logic [15:0] v, input logic [3:0] dp, input int k);
        logic [6:0] seg;
        seg = font_tbl(v[k*4 +: 4]);
`ifdef FND_LZB_EN
        if (k > 0 && (v >> (4 * k)) == 16'h0) seg = 7'h7F;
`endif
        return {~dp[k], seg};
    endfunction

    // Check cycles j = from..to of a frame showing (val, dp); caller sits in cycle from-1.
    task automatic scan(input logic [15:0] val, input logic [3:0] dp, input int from, input int to);
        for (int j = from; j <= to; j++) begin
            int         k;
            logic [3:0] d;
            @(negedge i_clk);
            k = (j - 1) / 4;
            d = ~(4'b0001 << k);
            chk($sformatf("digit j%0d", j), 32'(o_digit), 32'(d));
            chk($sformatf("font j%0d", j), 32'(o_font), 32'(exp_font(val, dp, k)));
            chk($sformatf("frame j%0d", j), 32'(o_frame), (j == 16) ? 32'd1 : 32'd0);
        end
    endtask

    // Advance to the next cycle with o_frame high, bounded.
    task automatic sync_frame();
        int n;
        n = 0;
        while (o_frame !== 1'b1 && n < 64) begin
            @(negedge i_clk);
            n++;
        end
        chk("sync_frame", 32'(o_frame), 32'd1);
    endtask

    task automatic chk_blank(input string tag);
        chk({tag, " digit"}, 32'(o_digit), 32'hF);
        chk({tag, " font"}, 32'(o_font), 32'hFF);
        chk({tag, " frame"}, 32'(o_frame), 32'd0);
    endtask

    initial begin
        i_reset = 1'b1;
        i_en    = 1'b0;
        i_load  = 1'b0;
        i_value = '0;
        i_dp    = '0;
        repeat (3) @(negedge i_clk);
        phase = "reset";
        chk_blank("rst");

        // Basic scan of 1234, taken at the first wrap.
        phase   = "scan1234";
        i_reset = 1'b0;
        i_en    = 1'b1;
        i_load  = 1'b1;
        i_value = 16'h1234;
        @(negedge i_clk);
        i_load = 1'b0;
        sync_frame();
        scan(16'h1234, 4'b0000, 1, 16);

        // Two loads mid-frame: the frame in progress still shows 1234, the last load appears next frame.
        phase   = "midload";
        i_load  = 1'b1;
        i_value = 16'h0000;
        @(negedge i_clk);
        i_value = 16'hABCD;
        @(negedge i_clk);
        i_load = 1'b0;
        scan(16'h1234, 4'b0000, 3, 16);
        scan(16'hABCD, 4'b0000, 1, 15);

        // Load landing on the wrap tick shows in the frame starting at that wrap.
        phase   = "wrapload";
        i_load  = 1'b1;
        i_value = 16'h8888;
        i_dp    = 4'b0100;
        scan(16'hABCD, 4'b0000, 16, 16);
        i_load = 1'b0;
        i_dp   = 4'b0000;
        scan(16'h8888, 4'b0100, 1, 9);

        // Disable while digit 2 is lit: blank for 10 cycles, then resume on digit 2.
        phase = "enable";
        i_en  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            chk_blank($sformatf("off%0d", i));
        end
        i_en = 1'b1;
        scan(16'h8888, 4'b0100, 10, 16);

        // Reset mid-scan with a pending load: blank next cycle, then zeros.
        phase = "midreset";
        scan(16'h8888, 4'b0100, 1, 5);
        i_load  = 1'b1;
        i_value = 16'h5678;
        @(negedge i_clk);
        i_load  = 1'b0;
        i_reset = 1'b1;
        @(negedge i_clk);
        chk_blank("rst2");
        i_reset = 1'b0;
        sync_frame();
        scan(16'h0000, 4'b0000, 1, 16);

        // Leading zeros with a dp on the top digit.
        phase   = "lzb";
        i_load  = 1'b1;
        i_value = 16'h0070;
        i_dp    = 4'b1000;
        @(negedge i_clk);
        i_load = 1'b0;
        i_dp   = 4'b0000;
        sync_frame();
        scan(16'h0070, 4'b1000, 1, 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
